uart_tx_feeder: RTL
===================

# uart_tx_feeder

Transmit-side buffer and launch controller that sits directly upstream of the UART transmitter. Host logic writes bytes into an internal FIFO at any rate. The feeder pops one byte at a time, presents it on `tx_din` with a one-cycle `tx_start` pulse, and holds off until the transmitter reports `tx_done_tick`. It decouples bursty producers from the serial line rate set by `s_tick`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width; must match the transmitter `din`.
- `ADDR_WIDTH`, 4: FIFO depth = 2^ADDR_WIDTH (16).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_en`  in  1  host write strobe; one byte per cycle.
- `wr_data`  in  DATA_WIDTH  byte to enqueue.
- `full`  out  1  FIFO holds 2^ADDR_WIDTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0 to 2^ADDR_WIDTH.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_din`  out  DATA_WIDTH  byte for the transmitter; valid while `tx_start` = 1, then held.
- `tx_done_tick`  in  1  one-cycle completion pulse from the transmitter.
- `busy`  out  1  a byte has been launched and its `tx_done_tick` is not yet seen.

## Operation
- FIFO: circular buffer. `wr_ptr` and `rd_ptr` are ADDR_WIDTH wide and wrap modulo depth. `count` tracks occupancy.
- `full` = (count == depth) and `empty` = (count == 0). Both are registered and derived from `count`.
- Write accept: `wr_en && !full`. On accept, store `wr_data` at `wr_ptr` and increment `wr_ptr`.
- Write while `full`: data is dropped, pointers are unchanged, and `overflow` = 1 on the next cycle for one cycle. `full` blocks writes even when a pop occurs on the same edge.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- FSM states (encoding in package): `IDLE`, `WAIT_DONE`.
  - `IDLE` with `!empty`: on the edge, set `tx_din` ← mem[rd_ptr], increment `rd_ptr`, set `tx_start` ← 1, set `busy` ← 1, and go to `WAIT_DONE`.
  - `IDLE` with `empty`: stay in `IDLE`; `tx_start` = 0.
  - `WAIT_DONE`: `tx_start` ← 0 on the first edge. On `tx_done_tick` = 1, set `busy` ← 0 and return to `IDLE`.
  - `tx_done_tick` received in `IDLE` is ignored.
- `tx_din` holds its last value between launches; it never returns to 0 except on reset.
- At most one byte is outstanding at the transmitter at any time.

## Timing
- Reset values:
  - `tx_start` = 0, `tx_din` = 0, `busy` = 0, `overflow` = 0.
  - `count` = 0, `empty` = 1, `full` = 0.
  - Pointers = 0; FSM = `IDLE`.
  - Memory contents are not reset.
- Latency from write accepted at edge k into an empty, idle block: `count` = 1 and `empty` = 0 after edge k; `tx_start` = 1 after edge k+1.
- `tx_start` is high for exactly one cycle per launch.
- Turnaround: `tx_done_tick` sampled at edge d gives `IDLE` after d. The next `tx_start` rises after d+1 if the FIFO is non-empty, giving back-to-back frames with no extra idle cycles.
- Reset asserted mid-operation, in any state: all registers take their reset values immediately and buffered bytes are discarded. The transmitter shares `reset`, so no stale `tx_done_tick` follows.
- Width rule: `count` is ADDR_WIDTH+1 bits so that depth is representable without aliasing to 0.

## Structure
- Shared package `uart_pkg`:
  - feeder FSM state localparams `IDLE`/`WAIT_DONE`;
  - default `DATA_WIDTH` = 8;
  - oversample constant 16, shared with the transmitter and receiver.
- Sub-module `uart_sync_fifo` (storage, pointers, count, full/empty, overflow). The launch FSM lives in the top `uart_tx_feeder`.
- The same `uart_sync_fifo` is reused on the receive side.

## Test plan
- Reset then single write 0xA5: `empty` falls one cycle after the write. `tx_start` pulses one cycle later with `tx_din` = 0xA5 and `busy` = 1. `tx_done_tick` after 8 cycles → `busy` = 0.
- Burst of 0x01, 0x02, 0x03 on consecutive cycles with the transmitter model acknowledging after 20 cycles each: three `tx_start` pulses in order 0x01, 0x02, 0x03, each one cycle after the previous `tx_done_tick`. `count` peaks at 2.
- Write 17 bytes with the transmitter stalled (no `tx_done_tick`):
  - byte 1 launches; bytes 2–17 fill the FIFO to `count` = 16 and `full` = 1;
  - an 18th write gives an `overflow` pulse, `count` stays 16, and no data changes.
- Pointer wrap: 40 bytes 0x00–0x27 streamed with a fast acknowledge → the transmitter receives all 40 in order, and `empty` = 1 at the end.
- Simultaneous write and pop at `count` = 3 → `count` stays 3 and the popped byte is the oldest.
- Reset asserted in `WAIT_DONE` with `count` = 5 → the next cycle shows `count` = 0, `empty` = 1, `busy` = 0, `tx_start` = 0. A later write of 0x5A launches normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, oversample ratio and the
// encoding of the transmit feeder launch FSM.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DONE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered count/full/empty and a
// one-cycle overflow pulse when a write is dropped. Used on both the
// transmit and receive sides of the UART.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;

  logic                  w_wrAccept;
  logic                  w_rdAccept;
  logic [ADDR_WIDTH:0]   w_countNext;

  // Full blocks writes even if a pop happens on the same edge; an empty FIFO never pops.
  assign w_wrAccept = i_wr_en && !r_full;
  assign w_rdAccept = i_rd_en && !r_empty;

  // Next occupancy: a simultaneous accepted write and pop leaves count unchanged.
  always_comb begin
    w_countNext = r_count;
    if (w_wrAccept && !w_rdAccept) begin
      w_countNext = r_count + CNT_ONE;
    end else if (w_rdAccept && !w_wrAccept) begin
      w_countNext = r_count - CNT_ONE;
    end
  end

  // Pointers, occupancy and flags; flags are registered from the next count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_rdAccept) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_count    <= w_countNext;
      r_full     <= (w_countNext == CNT_FULL);
      r_empty    <= (w_countNext == '0);
      r_overflow <= i_wr_en && r_full;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rdPtr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit feeder: buffers host bytes in a FIFO and launches them one at a
// time into the UART transmitter, waiting for each completion tick.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_din,
  input  logic                  tx_done_tick,
  output logic                  busy
);

  logic [0:0]            r_state;
  logic                  r_txStart;
  logic [DATA_WIDTH-1:0] r_txDin;
  logic                  r_busy;

  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_fifoData;
  logic                  w_empty;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifoData),
    .o_full     (full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  // Only pop while idle, so at most one byte is ever outstanding.
  assign w_pop = (r_state == IDLE) && !w_empty;

  // Launch FSM: pop and pulse tx_start from IDLE, then wait for the done tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_txStart <= 1'b0;
      r_txDin   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txStart <= 1'b0;
          if (w_pop) begin
            r_txDin   <= w_fifoData;
            r_txStart <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          r_txStart <= 1'b0;
          if (tx_done_tick) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_txStart <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign empty    = w_empty;
  assign tx_start = r_txStart;
  assign tx_din   = r_txDin;
  assign busy     = r_busy;

endmodule
